// File: rtl/scan_pkg.sv
// Shared types and constant tables for the breakout LED-matrix / 7-segment scanner.
package scan_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHOW, BLANK} state_t;
  typedef enum logic [1:0] {SRC_ENGINE, SRC_GAMEOVER, SRC_WIN} src_t;

  // Active-low {a,b,c,d,e,f,g} digit codes.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Rows are {red, green, blue}: red X inside a green border.
  localparam logic [23:0] GAMEOVER_ROM [0:7] = '{
    24'h81FF00, 24'h428100, 24'h248100, 24'h188100,
    24'h188100, 24'h248100, 24'h428100, 24'h81FF00
  };

  // Green-only smiley.
  localparam logic [23:0] WIN_ROM [0:7] = '{
    24'h003C00, 24'h004200, 24'h00A500, 24'h008100,
    24'h00A500, 24'h009900, 24'h004200, 24'h003C00
  };

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_LUT[digit] : SEG_OFF;
  endfunction

endpackage

// File: rtl/splash_rom.sv
// Combinational splash-frame lookup: sel=1 selects the win frame, sel=0 the game-over frame.
module splash_rom
  import scan_pkg::*;
(
  input  logic        sel,
  input  logic [2:0]  row,
  output logic [23:0] data
);

  assign data = sel ? WIN_ROM[row] : GAMEOVER_ROM[row];

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Row scanner for the 8x8 RGB matrix plus BCD score display and beep stretcher.
// Optional macro DIM_PWM_EN adds a brightness[2:0] input that shortens the lit part of each row.
module matrix_scan_scheduler
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 25000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned RESP_TO   = 8,
  parameter int unsigned BEEP_CYC  = 2500000
) (
  input  logic        CLK,
  input  logic        reset,
`ifdef DIM_PWM_EN
  input  logic [2:0]  brightness,
`endif
  input  logic        game_over,
  input  logic        game_finish,
  output logic        row_req,
  output logic [2:0]  row_addr,
  input  logic        row_vld,
  input  logic [23:0] row_data,
  input  logic        score_inc,
  input  logic        score_clr,
  output logic [27:0] led,
  output logic [3:0]  COM,
  output logic [6:0]  seg,
  output logic        beep
);

  state_t      state, state_next;
  src_t        src_q, src_fresh, src_now;
  logic [23:0] row_q, rom_row;
  logic [31:0] cnt, beep_cnt;
  logic [3:0]  ones, tens;
  logic        disp_on, tens_sel, pix_on, show_entry;

  always_comb begin
    if (game_over)        src_fresh = SRC_GAMEOVER;
    else if (game_finish) src_fresh = SRC_WIN;
    else                  src_fresh = SRC_ENGINE;
  end

  // The frame source is only re-sampled at row 0 so a frame never mixes sources.
  assign src_now = (row_addr == 3'd0) ? src_fresh : src_q;

  splash_rom u_splash_rom (
    .sel  (src_now == SRC_WIN),
    .row  (row_addr),
    .data (rom_row)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    row_req    = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (src_now == SRC_ENGINE) begin
          row_req    = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = SHOW;
        end
      end
      WAIT:    if (row_vld || cnt == RESP_TO - 1)  state_next = SHOW;
      SHOW:    if (cnt == DWELL_CYC - 1)           state_next = BLANK;
      BLANK:   if (cnt == BLANK_CYC - 1)           state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt      <= '0;
      row_addr <= 3'd0;
      src_q    <= SRC_ENGINE;
      row_q    <= '0;
    end else begin
      cnt <= (state_next != state) ? 32'd0 : cnt + 32'd1;
      case (state)
        REQ: begin
          if (row_addr == 3'd0) src_q <= src_fresh;
          if (src_now != SRC_ENGINE) row_q <= rom_row;
        end
        WAIT:  row_q <= row_vld ? row_data : 24'h000000;
        BLANK: if (state_next == REQ) row_addr <= row_addr + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef DIM_PWM_EN
  logic [31:0] show_len;
  assign show_len = ((32'(brightness) + 32'd1) * 32'(DWELL_CYC)) >> 3;
  assign pix_on   = (state == SHOW) && (cnt < show_len);
`else
  assign pix_on   = (state == SHOW);
`endif

  assign led = {1'b1, row_addr,
                pix_on ? ~{row_q[7:0], row_q[15:8], row_q[23:16]} : 24'hFFFFFF};

  always_ff @(posedge CLK) begin
    if (reset) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (score_clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (score_inc && !(ones == 4'd9 && tens == 4'd9)) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  // Digit mux advances once per row so both digits share the row refresh rate.
  assign show_entry = (state_next == SHOW) && (state != SHOW);

  always_ff @(posedge CLK) begin
    if (reset) begin
      disp_on  <= 1'b0;
      tens_sel <= 1'b1;
    end else if (show_entry) begin
      disp_on  <= 1'b1;
      tens_sel <= ~tens_sel;
    end
  end

  always_comb begin
    COM = 4'b1111;
    seg = SEG_OFF;
    if (disp_on) begin
      if (tens_sel) begin
        COM = 4'b1101;
        seg = seg_code(tens);
      end else begin
        COM = 4'b1110;
        seg = seg_code(ones);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset)                beep_cnt <= '0;
    else if (score_inc)       beep_cnt <= 32'(BEEP_CYC);
    else if (beep_cnt != '0)  beep_cnt <= beep_cnt - 32'd1;
  end

  assign beep = (beep_cnt != '0);

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Self-checking bench for matrix_scan_scheduler: table rows, random engine rows, splash, score, beep, reset.
module tb_matrix_scan_scheduler;

  localparam int DWELL = 4;
  localparam int BLANKC = 2;
  localparam int RESP = 8;
  localparam int BEEPC = 20;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        game_over = 1'b0, game_finish = 1'b0;
  logic        row_req, row_vld = 1'b0;
  logic [2:0]  row_addr;
  logic [23:0] row_data = '0;
  logic        score_inc = 1'b0, score_clr = 1'b0;
  logic [27:0] led;
  logic [3:0]  COM;
  logic [6:0]  seg;
  logic        beep;

  matrix_scan_scheduler #(
    .DWELL_CYC(DWELL), .BLANK_CYC(BLANKC), .RESP_TO(RESP), .BEEP_CYC(BEEPC)
  ) dut (
    .CLK(CLK), .reset(reset),
`ifdef DIM_PWM_EN
    .brightness(3'd7),
`endif
    .game_over(game_over), .game_finish(game_finish),
    .row_req(row_req), .row_addr(row_addr), .row_vld(row_vld), .row_data(row_data),
    .score_inc(score_inc), .score_clr(score_clr),
    .led(led), .COM(COM), .seg(seg), .beep(beep)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          lat;
    logic [23:0] data;
    logic [23:0] expLed;
  } vec_t;

  localparam logic [7:0] GO_RED   [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
  localparam logic [7:0] GO_GREEN [8] = '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
  localparam logic [7:0] WIN_GRN  [8] = '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C};

  int checks = 0, failures = 0;
  int rowModel = 0, scoreModel = 0;
  logic [3:0] lastCom = 4'hF;
  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic inc, input logic clr);
    score_inc = inc;
    score_clr = clr;
    @(negedge CLK);
    score_inc = 1'b0;
    score_clr = 1'b0;
    if (clr) scoreModel = 0;
    else if (inc && scoreModel < 99) scoreModel++;
  endtask

  function automatic logic [23:0] ledOf(input logic [23:0] d);
    return ~{d[7:0], d[15:8], d[23:16]};
  endfunction

  function automatic logic [23:0] splashLed(input bit win, input int r);
    return win ? ledOf({8'h00, WIN_GRN[r], 8'h00}) : ledOf({GO_RED[r], GO_GREEN[r], 8'h00});
  endfunction

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  task automatic checkReset();
    checkOutput("rst_row_req", 32'(row_req), 32'd0);
    checkOutput("rst_row_addr", 32'(row_addr), 32'd0);
    checkOutput("rst_led", 32'(led), 32'h08FF_FFFF);
    checkOutput("rst_com", 32'(COM), 32'hF);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_beep", 32'(beep), 32'd0);
  endtask

  // Entered at the negedge where the row's REQ cycle is visible; returns at the next row's REQ.
  task automatic scanRow(input int lat, input logic [23:0] data, input logic [23:0] expLed, input bit splash);
    int waits;
    logic [3:0] expCom;
    checkOutput("req_pulse", 32'(row_req), splash ? 32'd0 : 32'd1);
    checkOutput("req_addr", 32'(row_addr), 32'(rowModel));
    if (!splash) begin
      waits = (lat <= RESP) ? lat : RESP;
      for (int c = 1; c <= waits; c++) begin
        @(negedge CLK);
        row_vld = 1'b0;
        checkOutput("wait_req", 32'(row_req), 32'd0);
        checkOutput("wait_pix", 32'(led[23:0]), 32'hFF_FFFF);
        if (c == lat) begin
          row_vld  = 1'b1;
          row_data = data;
        end
      end
    end
    for (int c = 0; c < DWELL; c++) begin
      @(negedge CLK);
      row_vld = 1'b0;
      if (c == 0 && !splash && lat > RESP) begin
        row_vld  = 1'b1;
        row_data = data;
      end
      checkOutput("show_pix", 32'(led[23:0]), 32'(expLed));
      checkOutput("show_row", 32'(led[26:24]), 32'(rowModel));
      if (c == 0) begin
        expCom = (lastCom == 4'b1110) ? 4'b1101 : 4'b1110;
        checkOutput("digit_com", 32'(COM), 32'(expCom));
        checkOutput("digit_seg", 32'(seg),
                    32'(segOf(expCom == 4'b1110 ? scoreModel % 10 : scoreModel / 10)));
        lastCom = expCom;
      end
    end
    for (int c = 0; c < BLANKC; c++) begin
      @(negedge CLK);
      row_vld = 1'b0;
      checkOutput("blank_pix", 32'(led[23:0]), 32'hFF_FFFF);
      checkOutput("blank_req", 32'(row_req), 32'd0);
    end
    @(negedge CLK);
    rowModel = (rowModel + 1) % 8;
  endtask

  task automatic checkScore(input int s);
    int n;
    logic [3:0] want;
    for (int d = 0; d < 2; d++) begin
      want = (d == 0) ? 4'b1110 : 4'b1101;
      n = 0;
      while (COM !== want && n < 200) begin
        @(negedge CLK);
        n++;
      end
      if (COM !== want) checkOutput("com_timeout", 32'(COM), 32'(want));
      else checkOutput(d == 0 ? "seg_ones" : "seg_tens", 32'(seg),
                       32'(segOf(d == 0 ? s % 10 : s / 10)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, n, hc;
    logic [23:0] d;

    vecs[0] = '{2,  24'hFF0000, 24'hFFFF00};
    vecs[1] = '{1,  24'h00FF00, 24'hFF00FF};
    vecs[2] = '{3,  24'h0000FF, 24'h00FFFF};
    vecs[3] = '{8,  24'h123456, 24'hA9CBED};
    vecs[4] = '{9,  24'hFFFFFF, 24'hFFFFFF};
    vecs[5] = '{5,  24'h8001F0, 24'h0FFE7F};
    vecs[6] = '{2,  24'hA55A00, 24'hFFA55A};
    vecs[7] = '{10, 24'h0F0F0F, 24'hFFFFFF};

    repeat (2) @(negedge CLK);
    checkReset();
    reset = 1'b0;
    @(negedge CLK);

    $display("[TB] table-driven engine rows");
    for (int i = 0; i < 8; i++) scanRow(vecs[i].lat, vecs[i].data, vecs[i].expLed, 1'b0);

    $display("[TB] random engine rows");
    for (int i = 0; i < 19; i++) begin
      lat = int'($urandom_range(1, 10));
      d   = 24'($urandom());
      scanRow(lat, d, (lat <= RESP) ? ledOf(d) : 24'hFFFFFF, 1'b0);
    end

    $display("[TB] splash switching at row %0d", rowModel);
    game_over = 1'b1;
    for (int r = 3; r < 8; r++) begin
      d = 24'($urandom());
      scanRow(int'($urandom_range(1, 8)), d, ledOf(d), 1'b0);
    end
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 8; r++) begin
        if (f == 0 && r == 2) game_finish = 1'b1;
        if (f == 1 && r == 4) game_over = 1'b0;
        if (f == 2 && r == 5) game_finish = 1'b0;
        scanRow(0, 24'h0, splashLed(f == 2, r), 1'b1);
      end
    end
    for (int r = 0; r < 2; r++) begin
      d = 24'($urandom());
      scanRow(3, d, ledOf(d), 1'b0);
    end

    $display("[TB] reset during WAIT");
    checkOutput("t6_req", 32'(row_req), 32'd1);
    @(negedge CLK);
    reset = 1'b1;
    score_inc = 1'b1;
    @(negedge CLK);
    score_inc = 1'b0;
    checkReset();
    reset = 1'b0;
    row_vld = 1'b1;
    row_data = 24'hFFFFFF;
    @(negedge CLK);
    row_vld = 1'b0;
    rowModel = 0;
    lastCom = 4'hF;
    scoreModel = 0;
    scanRow(2, 24'h00FF00, 24'hFF00FF, 1'b0);
    scanRow(9, 24'h00FF00, 24'hFFFFFF, 1'b0);

    $display("[TB] score saturation and clear");
    for (int i = 0; i < 99; i++) applyStimulus(1'b1, 1'b0);
    checkScore(99);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat_beep", 32'(beep), 32'd1);
    checkScore(99);
    applyStimulus(1'b1, 1'b1);
    checkScore(0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    checkScore(10);
    for (int i = 0; i < 150; i++)
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    checkScore(scoreModel);

    $display("[TB] beep stretch and retrigger");
    n = 0;
    while (beep !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("beep_idle", 32'(beep), 32'd0);
    applyStimulus(1'b1, 1'b0);
    hc = 0;
    for (int k = 1; k < 200; k++) begin
      if (beep !== 1'b1) break;
      hc++;
      @(negedge CLK);
    end
    checkOutput("beep_single_len", 32'(hc), 32'(BEEPC));
    applyStimulus(1'b1, 1'b0);
    hc = 0;
    for (int k = 1; k < 200; k++) begin
      if (beep !== 1'b1) break;
      hc++;
      if (k == BEEPC / 2) score_inc = 1'b1;
      @(negedge CLK);
      if (score_inc) begin
        score_inc = 1'b0;
        if (scoreModel < 99) scoreModel++;
      end
    end
    checkOutput("beep_retrig_len", 32'(hc), 32'(BEEPC + BEEPC / 2));
    checkScore(scoreModel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_scan_scheduler.md
Name: matrix_scan_scheduler

Overview:
- Sequences the 8x8 tri-colour LED matrix and the 4-digit 7-segment display for the breakout game.
- Each row it either requests pixel data from the game engine over a request/valid handshake, or substitutes an internal splash frame (game-over / win).
- Also owns the BCD score counter (0-99) and the beep pulse stretcher, so the game logic only issues single-cycle events.

Parameters:
- DWELL_CYC, 25000, CLK cycles a row is driven (SHOW time).
- BLANK_CYC, 16, CLK cycles with all pixels off between rows (anti-ghosting).
- RESP_TO, 8, maximum CLK cycles to wait for row_vld after row_req.
- BEEP_CYC, 2500000, beep high time per hit event.

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- game_over  in  1  level; select game-over splash
- game_finish  in  1  level; select win splash
- row_req  out  1  one-cycle pulse requesting row data from game engine
- row_addr  out  3  row being requested; stable from row_req until SHOW exits
- row_vld  in  1  engine response strobe
- row_data  in  24  {red[7:0], green[7:0], blue[7:0]}, active-high pixel on, sampled when row_vld=1
- score_inc  in  1  one-cycle pulse: +1 point
- score_clr  in  1  one-cycle pulse: score to 00
- led  out  28  [0:23] active-low pixels R,G,B; [24:26] row index; [27] matrix enable
- COM  out  4  active-low digit enables
- seg  out  7  {a..g} active-low
- beep  out  1  buzzer drive

Behaviour:
- Reset values:
  - state = IDLE; row_req = 0; row_addr = 0.
  - led[0:23] all 1; led[24:26] = 0; led[27] = 1.
  - COM = 4'b1111; seg = 7'b1111111; beep = 0; score = 00.
- Reset mid-operation aborts any pending request without waiting for row_vld.
- FSM states and transitions:
  - IDLE: one cycle, then REQ.
  - REQ: latch frame source only when row_addr == 0.
    - Source priority: game_over > game_finish > engine.
    - If the source is engine: row_req = 1, go to WAIT.
    - Otherwise load the splash ROM row and go to SHOW.
  - WAIT: on row_vld, capture row_data and go to SHOW.
    - If no row_vld arrives within RESP_TO cycles, drive the row all-off and go to SHOW.
    - row_vld outside WAIT is ignored.
  - SHOW: drive the inverted captured row on led[0:23] and row_addr on led[24:26] for DWELL_CYC cycles, then go to BLANK.
  - BLANK: led[0:23] all 1 for BLANK_CYC cycles. Then row_addr increments (wraps 7->0) and the FSM goes to REQ.
- Frame source is changed only at row 0, so frames never tear. game_over/game_finish changes mid-frame take effect at the next row 0.
- Row period = 1 + DWELL_CYC + BLANK_CYC (+ WAIT latency, engine source only).
- 7-segment display:
  - Digit mux toggles ones/tens at each SHOW entry.
  - COM = 1110 shows the ones digit; COM = 1101 shows the tens digit.
  - Digits 2 and 3 are always off.
- Score:
  - BCD; ones wraps 9->0 with tens carry.
  - Saturates at 99: a further score_inc has no effect.
  - score_clr has priority over score_inc in the same cycle.
- Beep:
  - score_inc (including when saturated) loads a down-counter with BEEP_CYC.
  - beep = 1 while the counter is nonzero.
  - A retrigger reloads the counter to full length.
- Splash row patterns are fixed 24-bit constants. Win splash uses green only; game-over uses red and green.

Optional Feature:
- DIM_PWM_EN defined:
  - Adds input brightness[2:0].
  - In SHOW, pixels are driven only for the first (brightness+1)*DWELL_CYC/8 cycles, then forced off for the rest of SHOW.
  - brightness = 7 equals full on.
- DIM_PWM_EN undefined: no port, full dwell always.

Decomposition:
- Package scan_pkg:
  - FSM state enum {IDLE, REQ, WAIT, SHOW, BLANK}.
  - SEG_LUT[0:9] active-low 7-segment codes (0 = 7'b0000001, 1 = 7'b1001111, ...).
  - GAMEOVER_ROM[0:7] and WIN_ROM[0:7], each 24 bits.
- One sub-module: splash_rom (combinational; inputs sel and row, output 24-bit row).

Test Plan:
1. Engine mode, DWELL_CYC=4, BLANK_CYC=2: engine answers row_vld 2 cycles after row_req with row_data=24'hFF0000 → led[0:7]=0 and led[8:23]=all 1 for 4 cycles; rows cycle 0..7 then back to 0.
2. Engine never asserts row_vld, RESP_TO=8 → row_req once, exactly 8 WAIT cycles, then row shows all-off; the next row issues a new row_req.
3. game_over asserted while row_addr=3 → rows 3..7 still use the engine; from row 0 onward no row_req is issued and led shows GAMEOVER_ROM rows.
4. Issue 99 score_inc pulses, then 1 more → display 9/9 after 99; still 99 after 100; same-cycle score_clr+score_inc → 00.
5. score_inc, then a second score_inc at BEEP_CYC/2 → beep stays high continuously for 1.5*BEEP_CYC total.
6. Assert reset during WAIT → next cycle shows all reset values, including row_req=0; the late row_vld is ignored; IDLE→REQ restarts at row 0.
